mc_controller: RTL

//  Multi-cycle MIPS control unit. Sequences the shared datapath (regfile, alu, flopenr PC/IR, mux2 selects)
//  one instruction at a time: fetch, decode, execute, memory, writeback. Sits beside the datapath;

---
 rtl/mips_pkg.sv | 70 +++++++
 rtl/alu_decoder.sv | 30 +++
 rtl/mc_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } statetype;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FUNCT_ADD  = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB  = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_AND  = 6'b100100;
    localparam logic [FUNCT_W-1:0] FUNCT_OR   = 6'b100101;
    localparam logic [FUNCT_W-1:0] FUNCT_SLT  = 6'b101010;
    localparam logic [FUNCT_W-1:0] FUNCT_SLTU = 6'b101011;

    localparam logic [ALUC_W-1:0] ALU_ADD  = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 3'b110;
    localparam logic [ALUC_W-1:0] ALU_AND  = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_OR   = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 3'b111;
    localparam logic [ALUC_W-1:0] ALU_SLTU = 3'b011;

    // ALUOP_NONE leaves alucontrol at 000 in states that do not use the ALU
    typedef enum logic [1:0] {
        ALUOP_NONE  = 2'b00,
        ALUOP_ADD   = 2'b01,
        ALUOP_SUB   = 2'b10,
        ALUOP_FUNCT = 2'b11
    } aluop_t;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        aluop_t     aluop;
        logic       done;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's ALU request (and funct for R-type) to the 3-bit ALU function code.
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t                    aluop_i,
    input  logic [FUNCT_W-1:0]        funct_i,
    output logic [ALUC_W-1:0]         alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_AND;
        case (aluop_i)
            ALUOP_ADD: alucontrol_o = ALU_ADD;
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD:  alucontrol_o = ALU_ADD;
                    FUNCT_SUB:  alucontrol_o = ALU_SUB;
                    FUNCT_AND:  alucontrol_o = ALU_AND;
                    FUNCT_OR:   alucontrol_o = ALU_OR;
                    FUNCT_SLT:  alucontrol_o = ALU_SLT;
                    FUNCT_SLTU: alucontrol_o = ALU_SLTU;
                    default:    alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and select from the current state.
module mc_controller
    import mips_pkg::*;
#(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    output logic                 pcen,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 iord,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUC_W-1:0]    alucontrol,
    output logic                 instr_done,
    output logic [STATE_W-1:0]   state_dbg
);

    statetype state_q;
    statetype state_d;
    ctrl_t    ctrl;
    logic     branch_cond;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore control decode; unlisted outputs stay 0
    always_comb begin
        state_d = FETCH;
        ctrl    = '0;
        case (state_q)
            FETCH: begin
                ctrl.irwrite = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.pcwrite = 1'b1;
                state_d      = DECODE;
            end
            DECODE: begin
                ctrl.alusrcb = 2'b11;
                ctrl.aluop   = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_BNE: begin
                        if (SUPPORT_BNE) state_d = BEQEX;
                        else             ctrl.done = 1'b1;
                    end
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default:      ctrl.done = 1'b1;
                endcase
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_ADD;
                state_d      = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
                state_d   = MEMWB;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.done     = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.done     = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
                state_d      = RTYPEWB;
            end
            RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.done     = 1'b1;
            end
            BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.branch  = 1'b1;
                ctrl.done    = 1'b1;
            end
            ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_ADD;
                state_d      = ADDIWB;
            end
            ADDIWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.done     = 1'b1;
            end
            JEX: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
                ctrl.done    = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // bne reuses BEQEX with the zero flag inverted
    assign branch_cond = (SUPPORT_BNE && (op == OP_BNE)) ? ~zero : zero;

    // Write enables and the done pulse are held off while reset is asserted
    assign pcen       = ~reset & (ctrl.pcwrite | (ctrl.branch & branch_cond));
    assign memwrite   = ~reset & ctrl.memwrite;
    assign irwrite    = ~reset & ctrl.irwrite;
    assign regwrite   = ~reset & ctrl.regwrite;
    assign instr_done = ~reset & ctrl.done;
    assign iord       = ctrl.iord;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign pcsrc      = ctrl.pcsrc;
    assign state_dbg  = state_q;

    alu_decoder u_alu_decoder (
        .aluop_i      (ctrl.aluop),
        .funct_i      (funct),
        .alucontrol_o (alucontrol)
    );

endmodule
